// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin poller that collects length-prefixed blocks from
// up to NCH channel processors over a shared 16-bit bus and forwards them,
// one registered word per cycle, to a single downstream consumer.
//
// A block is a control word (CW) followed by L data words:
//   CW[15]    : must be 1 for a valid block header
//   CW[14:9]  : channel number the processor believes it is
//   CW[8:0]   : L, number of data words that follow (1..511)
// The CW itself is forwarded downstream together with the data words.
module chan_arbiter #(
    parameter int NCH = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic [NCH-1:0]  give,
    input  logic [NCH-1:0]  have,
    input  logic [15:0]     din,
    input  logic [NCH-1:0]  chan_en,
    input  logic            dready,
    output logic [15:0]     dout,
    output logic            dvalid,
    output logic            blk_done,
    output logic            err,
    output logic [31:0]     blk_cnt,
    output logic [15:0]     err_cnt
);

    // Pointer width; a single-channel build still needs a one-bit pointer.
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        POLL = 2'd0,   // scanning for a channel with a control word
        DATA = 2'd1,   // streaming the data words of the current block
        SKIP = 2'd2    // one dead cycle after a rejected control word
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   ptr_inc;
    logic [8:0]      remaining;
    logic [8:0]      next_remaining;

    logic            give_cur;     // give for the channel under the pointer
    logic            have_cur;     // acknowledge from that channel
    logic            accept;       // transfer happens this cycle
    logic            cw_ok;        // CW header bit set and non-zero length
    logic            cw_chan_bad;  // CW names a different channel than ptr
    logic            fwd;          // word on din goes downstream
    logic            done_evt;     // last word of a good block accepted
    logic            err_evt;      // protocol error detected this cycle

    // Round-robin successor of the current pointer, wrapping at NCH-1.
    assign ptr_inc     = (ptr == PW'(NCH - 1)) ? '0 : ptr + 1'b1;

    assign have_cur    = have[ptr];
    assign accept      = give_cur & have_cur;
    assign cw_ok       = din[15] & (din[8:0] != 9'd0);
    assign cw_chan_bad = (din[14:9] != 6'(ptr));

    // State register: FSM state, channel pointer and remaining word count.
    // NOTE: the reset here is synchronous -- it is only a term in the
    // clocked branch, so nothing changes until the next rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= POLL;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state     <= next_state;
            ptr       <= next_ptr;
            remaining <= next_remaining;
        end
    end

    // Next-state logic: decide transitions and the per-cycle events.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned (no latches).
        next_state     = state;
        next_ptr       = ptr;
        next_remaining = remaining;
        fwd            = 1'b0;
        done_evt       = 1'b0;
        err_evt        = 1'b0;

        case (state)
            POLL: begin
                // With dready low nothing moves; the scan simply pauses.
                if (dready) begin
                    if (accept) begin
                        if (cw_ok) begin
                            // Good header: forward it and start the block.
                            // A wrong channel field is reported but tolerated.
                            next_state     = DATA;
                            next_remaining = din[8:0];
                            fwd            = 1'b1;
                            err_evt        = cw_chan_bad;
                        end else begin
                            // Bad header is swallowed; channel gets skipped.
                            next_state = SKIP;
                            err_evt    = 1'b1;
                        end
                    end else begin
                        // Disabled or idle channel: try the next one.
                        next_ptr = ptr_inc;
                    end
                end
            end

            DATA: begin
                // dready low is a plain stall: no give, count holds.
                if (dready) begin
                    if (have_cur) begin
                        fwd            = 1'b1;
                        next_remaining = remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            done_evt   = 1'b1;
                            next_state = POLL;
                            next_ptr   = ptr_inc;
                        end
                    end else begin
                        // Underrun: abandon the block, move past the channel.
                        err_evt        = 1'b1;
                        next_state     = POLL;
                        next_ptr       = ptr_inc;
                        next_remaining = '0;
                    end
                end
            end

            SKIP: begin
                next_state = POLL;
                next_ptr   = ptr_inc;
            end

            default: begin
                next_state = POLL;
            end
        endcase
    end

    // Output logic: request the pointed-to channel when the consumer can take
    // a word. chan_en matters only while hunting for a header, so a block in
    // flight always completes even if its channel is disabled meanwhile.
    always_comb begin
        give_cur = 1'b0;
        if (!reset && dready) begin
            case (state)
                POLL:    give_cur = chan_en[ptr];
                DATA:    give_cur = 1'b1;
                default: give_cur = 1'b0;
            endcase
        end
    end

    assign give = give_cur ? (NCH'(1) << ptr) : '0;

    // Registered downstream port, status pulses and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dvalid   <= 1'b0;
            blk_done <= 1'b0;
            err      <= 1'b0;
            blk_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            dvalid   <= fwd;
            blk_done <= done_evt;
            err      <= err_evt;
            if (fwd) begin
                dout <= din;
            end
            // Good-block count wraps naturally at 2^32.
            if (done_evt) begin
                blk_cnt <= blk_cnt + 32'd1;
            end
            // Error count sticks at all-ones instead of wrapping.
            if (err_evt && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
